// File: rtl/alu_checker.sv
// alu_checker: checks observed ALU results (in_c) against a built-in reference of the ALU.
// Latency: each accepted beat is reflected in the tallies 2 cycles after its acceptance edge.
// Backpressure: in_ready is high only in RUN until num_vec beats are taken; with
//   ALU_CHK_STOP_ON_FAIL_EN defined, the first mismatch ends the run early.
module alu_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_c,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [31:0]      first_fail_exp,
    output logic [31:0]      first_fail_got,
    output logic             fail_flag
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;

    logic             r_s1_vld;
    logic [31:0]      r_s1_exp;
    logic [31:0]      r_s1_got;
    logic [CNT_W-1:0] r_s1_idx;
    logic             r_s2_vld;
    logic [31:0]      r_s2_exp;
    logic [31:0]      r_s2_got;
    logic [CNT_W-1:0] r_s2_idx;

    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_ff_idx;
    logic [31:0]      r_ff_exp;
    logic [31:0]      r_ff_got;
    logic             r_fail_flag;

    logic [31:0]      w_exp;
    logic [4:0]       w_sh;
    logic             w_accept;
    logic             w_clear;
    logic             w_s2_mis;
    logic             w_stop;
    logic [CNT_W-1:0] w_acc_nxt;

    assign w_sh      = in_b[4:0];
    assign w_accept  = in_valid & r_in_ready;
    assign w_clear   = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_s2_mis  = r_s2_vld & (r_s2_exp != r_s2_got);
    assign w_acc_nxt = r_acc_cnt + CNT_ONE;

`ifdef ALU_CHK_STOP_ON_FAIL_EN
    // First mismatch of the run aborts: stop accepting and flush stage 1.
    assign w_stop = w_s2_mis & ~r_fail_flag;
`else
    assign w_stop = 1'b0;
`endif

    // Reference ALU result for the beat currently on the input bus.
    always_comb begin
        w_exp = 32'd0;
        case (in_op)
            3'b000:  w_exp = in_a + in_b;
            3'b001:  w_exp = in_a - in_b;
            3'b010:  w_exp = in_a & in_b;
            3'b011:  w_exp = in_a | in_b;
            3'b100:  w_exp = in_a >> w_sh;
            3'b101:  w_exp = $unsigned($signed(in_a) >>> w_sh);
            default: w_exp = 32'd0;
        endcase
    end

    // Run control FSM with registered handshake and status outputs.
    // DRAIN exits on the edge where stage 2 retires its last beat, so done
    // and the final tallies become visible together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_acc_cnt  <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_acc_cnt <= '0;
                        if (num_vec != '0) begin
                            r_state    <= S_RUN;
                            r_num      <= num_vec;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                        end else begin
                            r_state    <= S_DONE;
                            r_num      <= '0;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_stop) begin
                        r_state    <= S_DRAIN;
                        r_in_ready <= 1'b0;
                    end else if (w_accept) begin
                        r_acc_cnt <= w_acc_nxt;
                        if (w_acc_nxt == r_num) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_s1_vld) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-stage compare pipeline plus saturating tallies and first-fail capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_got    <= '0;
            r_s1_idx    <= '0;
            r_s2_vld    <= 1'b0;
            r_s2_exp    <= '0;
            r_s2_got    <= '0;
            r_s2_idx    <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_ff_idx    <= '0;
            r_ff_exp    <= '0;
            r_ff_got    <= '0;
            r_fail_flag <= 1'b0;
        end else if (w_clear) begin
            r_s1_vld    <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_ff_idx    <= '0;
            r_ff_exp    <= '0;
            r_ff_got    <= '0;
            r_fail_flag <= 1'b0;
        end else begin
            r_s1_vld <= w_accept & ~w_stop;
            if (w_accept) begin
                r_s1_exp <= w_exp;
                r_s1_got <= in_c;
                r_s1_idx <= r_acc_cnt;
            end
            r_s2_vld <= r_s1_vld & ~w_stop;
            r_s2_exp <= r_s1_exp;
            r_s2_got <= r_s1_got;
            r_s2_idx <= r_s1_idx;
            if (r_s2_vld) begin
                if (!w_s2_mis) begin
                    if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_ONE;
                end else begin
                    if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
                    if (!r_fail_flag) begin
                        r_fail_flag <= 1'b1;
                        r_ff_idx    <= r_s2_idx;
                        r_ff_exp    <= r_s2_exp;
                        r_ff_got    <= r_s2_got;
                    end
                end
            end
        end
    end

    assign in_ready       = r_in_ready;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_exp = r_ff_exp;
    assign first_fail_got = r_ff_got;
    assign fail_flag      = r_fail_flag;

endmodule

// File: tb/tb_alu_checker.sv
// tb_alu_checker: randomized and directed runs against a behavioural ALU model.
// Accepted beats push expected running tallies into a queue; a monitor pops
//   and compares them when they are due, decoupled from the stimulus driver.
module tb_alu_checker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] num_vec;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b, in_c;
    logic [2:0]  in_op;
    logic        busy, done, fail_flag;
    logic [15:0] pass_cnt, fail_cnt, first_fail_idx;
    logic [31:0] first_fail_exp, first_fail_got;

`ifdef ALU_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_BUILD = 1'b1;
`else
    localparam bit STOP_BUILD = 1'b0;
`endif

    alu_checker #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_vec(num_vec),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_c(in_c),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp),
        .first_fail_got(first_fail_got), .fail_flag(fail_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] p;
        logic [15:0] f;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] qa[$], qb[$], qc[$];
    logic [2:0]  qop[$];

    int          n_chk = 0;
    int          n_fail = 0;
    int          ncyc = 0;
    int          last_acc_cyc = 0;
    int          run_id = 0;
    int          seen_run = 0;
    int          m_acc = 0;
    logic [15:0] m_pass = 0, m_fail = 0, m_idx = 0;
    logic [31:0] m_exp = 0, m_got = 0;
    bit          m_flag = 0, m_stopped = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference ALU from the operation table.
    function automatic logic [31:0] model_exp(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        int unsigned sh;
        sh = 32'(b[4:0]);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a >> sh;
            3'd5: return a[31] ? ~((~a) >> sh) : (a >> sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    // Monitor: checks due tallies, then records newly accepted beats in the model.
    task automatic monitor();
        sb_t         e;
        logic [31:0] x;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!reset_n) begin
                sb_q.delete();
            end else begin
                if (run_id != seen_run) begin
                    seen_run = run_id;
                    m_pass = 0; m_fail = 0; m_idx = 0; m_exp = 0; m_got = 0;
                    m_flag = 0; m_stopped = 0; m_acc = 0;
                end
                while (sb_q.size() > 0 && sb_q[0].due == ncyc) begin
                    e = sb_q.pop_front();
                    chk("tally_pass", 32'(pass_cnt), 32'(e.p));
                    chk("tally_fail", 32'(fail_cnt), 32'(e.f));
                end
                if (in_valid && in_ready) begin
                    m_acc++;
                    last_acc_cyc = ncyc;
                    if (!m_stopped) begin
                        x = model_exp(in_a, in_b, in_op);
                        if (x == in_c) m_pass++;
                        else begin
                            m_fail++;
                            if (!m_flag) begin
                                m_flag = 1; m_idx = 16'(m_acc - 1); m_exp = x; m_got = in_c;
                                if (STOP_BUILD) m_stopped = 1;
                            end
                        end
                        e.due = ncyc + 3; e.p = m_pass; e.f = m_fail;
                        sb_q.push_back(e);
                    end
                end
            end
        end
    endtask

    // Starts a run and offers the queued beats; gap_mode 0=b2b, 1=alternate, 2=random.
    task automatic drive_run(input int n, input int gap_mode, input bit mid_start, input int abort_at);
        int i, budget;
        bit acc, give, early;
        @(posedge clk); #1;
        run_id++;
        start = 1'b1; num_vec = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        i = 0; budget = 0; early = 0;
        while (i < n && budget < 300 && !early) begin
            give = (gap_mode == 0) || (gap_mode == 1 && budget % 2 == 0) ||
                   (gap_mode == 2 && $urandom_range(0, 1) == 1);
            in_valid = give;
            if (i < qa.size()) begin
                in_a = qa[i]; in_b = qb[i]; in_op = qop[i]; in_c = qc[i];
            end
            start   = mid_start && budget == 3;
            num_vec = (mid_start && budget == 3) ? 16'd2 : 16'(n);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (done && !busy) early = 1;
            @(posedge clk); #1;
            if (acc) i++;
            budget++;
            if (abort_at > 0 && i == abort_at) break;
        end
        in_valid = 1'b0; start = 1'b0; num_vec = 16'(n);
        if (budget >= 300) chk("run_timeout_beats", 32'(i), 32'(n));
    endtask

    // Waits for done and compares end-of-run state against the model.
    task automatic finish_run(input int n);
        int k;
        bit seen;
        wait_neg();
        chk("in_ready_low_after_run", 32'(in_ready), 32'd0);
        seen = done; k = 1;
        while (!seen && k < 20) begin
            wait_neg(); k++; seen = done;
        end
        if (!seen) chk("done_timeout", 32'(done), 32'd1);
        else if (n == 0) chk("nv0_done_latency", 32'(k), 32'd1);
        else if (!(STOP_BUILD && m_flag)) chk("done_latency", 32'(ncyc - last_acc_cyc), 32'd3);
        chk("end_pass", 32'(pass_cnt), 32'(m_pass));
        chk("end_fail", 32'(fail_cnt), 32'(m_fail));
        chk("end_flag", 32'(fail_flag), 32'(m_flag));
        chk("end_idx", 32'(first_fail_idx), 32'(m_idx));
        chk("end_exp", first_fail_exp, m_exp);
        chk("end_got", first_fail_got, m_got);
        chk("end_busy", 32'(busy), 32'd0);
        repeat (3) wait_neg();
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_pass", 32'(pass_cnt), 32'(m_pass));
        chk("hold_fail", 32'(fail_cnt), 32'(m_fail));
    endtask

    task automatic add_beat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input bit bad);
        logic [31:0] c;
        c = model_exp(a, b, op);
        if (bad) c = c ^ 32'h1;
        qa.push_back(a); qb.push_back(b); qop.push_back(op); qc.push_back(c);
    endtask

    task automatic clear_beats();
        qa.delete(); qb.delete(); qop.delete(); qc.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass_cnt), 32'd0);
        chk({tag, "_fail"}, 32'(fail_cnt), 32'd0);
        chk({tag, "_flag"}, 32'(fail_flag), 32'd0);
        chk({tag, "_idx"}, 32'(first_fail_idx), 32'd0);
        chk({tag, "_exp"}, first_fail_exp, 32'd0);
        chk({tag, "_got"}, first_fail_got, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; num_vec = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; in_c = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_neg();
        check_all_zero("reset");

        // Directed: four correct results, back to back.
        clear_beats();
        add_beat(32'hFFFFFFFF, 32'd1, 3'b000, 0);
        add_beat(32'h00000000, 32'd1, 3'b001, 0);
        add_beat(32'h80000000, 32'd31, 3'b100, 0);
        add_beat(32'h80000000, 32'd4, 3'b101, 0);
        chk("vec_add_wrap", qc[0], 32'h00000000);
        chk("vec_sub_wrap", qc[1], 32'hFFFFFFFF);
        chk("vec_srl", qc[2], 32'h00000001);
        chk("vec_sra", qc[3], 32'hF8000000);
        drive_run(4, 0, 0, 0);
        finish_run(4);
        chk("d4_pass", 32'(pass_cnt), 32'd4);
        chk("d4_fail", 32'(fail_cnt), 32'd0);

        // Directed: one AND mismatch at beat 1.
        clear_beats();
        add_beat(32'h12345678, 32'h0000FFFF, 3'b011, 0);
        qa.push_back(32'hF0); qb.push_back(32'h3C); qop.push_back(3'b010); qc.push_back(32'h31);
        add_beat(32'h00000010, 32'h00000003, 3'b110, 0);
        drive_run(3, 0, 0, 0);
        finish_run(3);
        chk("d3_fail", 32'(fail_cnt), 32'd1);
        chk("d3_pass", 32'(pass_cnt), 32'd2);
        chk("d3_idx", 32'(first_fail_idx), 32'd1);
        chk("d3_exp", first_fail_exp, 32'h30);
        chk("d3_got", first_fail_got, 32'h31);

        // Empty run.
        clear_beats();
        drive_run(0, 0, 0, 0);
        finish_run(0);
        chk("nv0_pass", 32'(pass_cnt), 32'd0);
        chk("nv0_fail", 32'(fail_cnt), 32'd0);
        chk("nv0_in_ready", 32'(in_ready), 32'd0);

        // Alternating valid, start pulse mid-run must be ignored.
        clear_beats();
        for (int i = 0; i < 5; i++) add_beat($urandom, $urandom, 3'($urandom_range(0, 7)), 0);
        drive_run(5, 1, 1, 0);
        finish_run(5);
        chk("alt_pass", 32'(pass_cnt), 32'd5);
        in_valid = 1'b1;
        repeat (3) wait_neg();
        in_valid = 1'b0;
        chk("alt_accepted", 32'(m_acc), 32'd5);

        // Beats 2 and 4 wrong: stop-on-fail build ends early.
        clear_beats();
        for (int i = 0; i < 6; i++)
            add_beat($urandom, $urandom, 3'($urandom_range(0, 5)), (i == 2) || (i == 4));
        drive_run(6, 0, 0, 0);
        finish_run(6);
        chk("d6_fail", 32'(fail_cnt), STOP_BUILD ? 32'd1 : 32'd2);
        chk("d6_pass", 32'(pass_cnt), STOP_BUILD ? 32'd2 : 32'd4);
        chk("d6_idx", 32'(first_fail_idx), 32'd2);
        chk("d6_done", 32'(done), 32'd1);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 14);
            clear_beats();
            for (int i = 0; i < n; i++)
                add_beat($urandom, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
            drive_run(n, r % 3, 0, 0);
            finish_run(n);
        end

        // Reset in the middle of an 8-beat run after 3 accepted beats.
        clear_beats();
        for (int i = 0; i < 8; i++) add_beat($urandom, $urandom, 3'($urandom_range(0, 7)), 0);
        drive_run(8, 0, 0, 3);
        reset_n = 1'b0;
        wait_neg();
        check_all_zero("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) wait_neg();
        check_all_zero("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of vector count, pass/fail counters and fail index.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins a checking run.
REQ-005 SHALL have port num_vec  input  CNT_W  number of vectors in the run, sampled on start.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1)  observed-vector handshake.
REQ-007 SHALL have ports in_a, in_b (input, 32), in_op (input, 3), in_c (input, 32)  ALU operands, ALUOp and DUT result C.
REQ-008 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-009 SHALL have port done  output  1  high while in DONE.
REQ-010 SHALL have ports pass_cnt, fail_cnt  output  CNT_W  compare tallies.
REQ-011 SHALL have ports first_fail_idx (output, CNT_W), first_fail_exp and first_fail_got (output, 32), fail_flag (output, 1)  first-mismatch capture.

Function
REQ-012 SHALL compute expected C per in_op: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A>>B[4:0] logical, 101 A>>>B[4:0] arithmetic, 110/111 zero; add/sub wrap modulo 2^32.
REQ-013 SHALL use FSM states IDLE, RUN, DRAIN, DONE.
REQ-014 SHALL move IDLE or DONE -> RUN on start with num_vec>0, clearing counters, fail_flag and capture registers and latching num_vec.
REQ-015 SHALL move IDLE or DONE -> DONE on start with num_vec=0, counters zero.
REQ-016 SHALL ignore start in RUN and DRAIN.
REQ-017 SHALL assert in_ready only in RUN while accepted count < latched num_vec; a beat is accepted when in_valid and in_ready are both high.
REQ-018 SHALL pipeline accepted beats in two stages: stage 1 registers inputs and expected value; stage 2 compares and updates tallies; tallies reflect a beat exactly 2 cycles after its acceptance edge.
REQ-019 SHALL increment pass_cnt on match, else fail_cnt; both saturate at all-ones.
REQ-020 SHALL on the first mismatch of a run set fail_flag and capture zero-based beat index, expected and got values; later mismatches SHALL NOT overwrite the capture.
REQ-021 SHALL move RUN -> DRAIN on the cycle the last beat is accepted, and DRAIN -> DONE once both stages are empty.
REQ-022 SHALL accept back-to-back beats at one per cycle with no bubbles.
REQ-023 SHALL hold all tallies and captures stable in DONE until the next accepted start.

Reset
REQ-024 SHALL on reset_n low immediately enter IDLE and drive in_ready, busy, done, fail_flag low and all counters and capture registers zero, including mid-run.
REQ-025 SHALL discard pipeline contents on reset; no tally updates from pre-reset beats.

Configuration
REQ-026 SHALL honour macro ALU_CHK_STOP_ON_FAIL_EN: when defined, the cycle stage 2 detects the first mismatch the FSM SHALL go to DRAIN (in_ready low next cycle) and the beat in stage 1 SHALL be discarded uncounted; when undefined, runs always process all num_vec beats.

Verification
REQ-027 Reset mid-RUN after 3 of 8 beats -> next cycle all outputs zero, state IDLE, no late tally change.
REQ-028 num_vec=4, correct results for ops 000 (A=0xFFFFFFFF,B=1,C=0), 001 (A=0,B=1,C=0xFFFFFFFF), 100 (A=0x80000000,B=31,C=1), 101 (A=0x80000000,B=4,C=0xF8000000), back-to-back -> pass_cnt=4, fail_cnt=0, done 2 cycles after last accept + DRAIN exit.
REQ-029 num_vec=3, beat 1 op 010 A=0xF0,B=0x3C,C=0x31 -> fail_cnt=1, pass_cnt=2, first_fail_idx=1, exp=0x30, got=0x31.
REQ-030 start with num_vec=0 -> done next cycle, counters 0, in_ready never high.
REQ-031 in_valid toggled every other cycle, num_vec=5 -> exactly 5 accepted, in_ready drops after 5th, start during RUN ignored.
REQ-032 With ALU_CHK_STOP_ON_FAIL_EN, num_vec=6, beats 2 and 4 wrong -> fail_cnt=1, pass_cnt=2, first_fail_idx=2, done asserted; without macro -> fail_cnt=2, pass_cnt=4.
